// File: rtl/dyse_sim_pkg.sv
// Shared types for the network simulation blocks: trajectory record layout
// and recorder state encoding.
package dyse_sim_pkg;

    localparam int STATE_W = 8;
    localparam int ITER_W  = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_DONE   = 2'd2
    } rec_state_e;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic [ITER_W-1:0]  iter;
        logic               last;
    } traj_rec_t;

    localparam int REC_W = $bits(traj_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is shown combinationally
// from storage and forced to zero while empty.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_wr_en;
    logic          w_rd_en;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(DEPTH));
    // A push into a full FIFO is accepted only when the head leaves the same cycle.
    assign w_wr_en = push && (!full || pop);
    assign w_rd_en = pop && !empty;
    assign dout    = empty ? '0 : r_mem[r_rd_ptr];
    assign count   = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/trajectory_recorder.sv
// Captures one record per iteration change of the simulation datapath into
// a FIFO, ending the run with a record flagged last at steady state.
//   state     | meaning
//   ST_IDLE   | no run active, datapath ignored
//   ST_RECORD | capturing a record on first cycle, iteration change or steady state
//   ST_DONE   | steady-state record captured, waiting for run_start
module trajectory_recorder
    import dyse_sim_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int SW    = STATE_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_start,
    input  logic [SW-1:0]          network_state,
    input  logic [ITER_W-1:0]      iteration_number,
    input  logic                   steady_state,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [SW-1:0]          out_state,
    output logic [ITER_W-1:0]      out_iter,
    output logic                   out_last,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count
);
    rec_state_e        r_state;
    logic              r_first;
    logic [ITER_W-1:0] r_last_iter;
    logic              r_overflow;

    traj_rec_t w_rec;
    traj_rec_t w_head;
    logic      w_empty;
    logic      w_full;
    logic      w_pop;
    logic      w_push;
    logic      w_drop;

    assign w_pop  = !w_empty && out_ready;
    assign w_push = (r_state == ST_RECORD) && !run_start &&
                    (r_first || (iteration_number != r_last_iter) || steady_state);
    assign w_drop = w_push && w_full && !w_pop;

    always_comb begin
        w_rec       = '0;
        w_rec.state = network_state;
        w_rec.iter  = iteration_number;
        w_rec.last  = steady_state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_first     <= 1'b0;
            r_last_iter <= '0;
            r_overflow  <= 1'b0;
        end else if (run_start) begin
            r_state    <= ST_RECORD;
            r_first    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            // Tracking advances on every push, including one that gets dropped.
            if (w_push) begin
                r_last_iter <= iteration_number;
                r_first     <= 1'b0;
            end
            if (w_drop) r_overflow <= 1'b1;
            if (r_state == ST_RECORD && steady_state) r_state <= ST_DONE;
        end
    end

    sync_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst),
        .flush (run_start),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_rec),
        .dout  (w_head),
        .empty (w_empty),
        .full  (w_full),
        .count (count)
    );

    assign out_valid = !w_empty;
    assign out_state = w_head.state;
    assign out_iter  = w_head.iter;
    assign out_last  = w_head.last;
    assign overflow  = r_overflow;

endmodule
